pipe_stage_reg: RTL

Parametrised pipeline stage register for the pipelined MIPS datapath. It replaces the fixed-width, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that has:
- a valid/ready handshake;
- an optional two-entry skid buffer;
- synchronous flush, with bubbles carrying all-zero control;
- a saturating stall-cycle counter for performance debug.

Each stage boundary instantiates one copy, with widths set to that boundary's control and data bundle.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: per-boundary
// bundle widths, the occupancy state encoding and the bubble control value.
package pipe_pkg;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 143;
  localparam int EXMEM_CTRL_W = 7;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 3;
  localparam int MEMWB_DATA_W = 69;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } pipe_state_e;

  // Replicated across the control width so bubbles keep write enables inert.
  localparam bit CTRL_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry
// skid buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = EXMEM_CTRL_W,
  parameter int DATA_W = EXMEM_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  input  logic              stall_cnt_clr_i
);

  pipe_state_e       state_q, state_n;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_n, skid_ctrl_q, skid_ctrl_n;
  logic [DATA_W-1:0] head_data_q, head_data_n, skid_data_q, skid_data_n;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              push, pop;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign ctrl_o      = out_valid_o ? head_ctrl_q : {CTRL_W{CTRL_BUBBLE}};
  assign data_o      = head_data_q;
  assign stall_cnt_o = stall_cnt_q;

  // Flush wins over every transfer and leaves the payload registers untouched.
  always_comb begin
    state_n     = state_q;
    head_ctrl_n = head_ctrl_q;
    head_data_n = head_data_q;
    skid_ctrl_n = skid_ctrl_q;
    skid_data_n = skid_data_q;
    if (flush_i) begin
      state_n = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            head_ctrl_n = ctrl_i;
            head_data_n = data_i;
            state_n     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_ctrl_n = ctrl_i;
            head_data_n = data_i;
          end else if (push) begin
            skid_ctrl_n = ctrl_i;
            skid_data_n = data_i;
            state_n     = ST_TWO;
          end else if (pop) begin
            state_n = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_ctrl_n = skid_ctrl_q;
            head_data_n = skid_data_q;
            state_n     = ST_ONE;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_n;
      head_ctrl_q <= head_ctrl_n;
      head_data_q <= head_data_n;
      skid_ctrl_q <= skid_ctrl_n;
      skid_data_q <= skid_data_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_clr_i) begin
      stall_cnt_q <= '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // The skid variant breaks the ready path by registering it from the next state.
  generate
    if (SKID != 0) begin : g_skid
      logic ready_q;
      always_ff @(posedge clk_i) begin
        if (!rst_n) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_n != ST_TWO);
        end
      end
      assign in_ready_o = ready_q;
    end else begin : g_noskid
      assign in_ready_o = !out_valid_o || out_ready_i;
    end
  endgenerate

endmodule
